reg_file: RTL and testbench

Architectural register file with rename tags: the issue/commit counterpart of the reorder buffer. It holds x0–x31, records which ROB entry will produce each pending register, retires values on ROB commit, and resolves decoder source operands to either a value or a ROB dependency tag. It sits between the decoder (operand lookup, issue), the ROB (issue-pollute, commit, ready/value query) and RS/LSB (which consume the resolved operands).

---
 rtl/reg_file.sv | 109 ++++++++++
 tb/tb_reg_file.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Architectural register file (x0-x31) with rename tags: records the ROB entry
// that will produce each pending register and resolves source operands.
module reg_file #(
    parameter int ROB_BIT = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_up,
    input  logic               issue_pollute,
    input  logic [4:0]         issue_reg_id,
    input  logic [ROB_BIT-1:0] issue_rob_entry,
    input  logic               rob_commit,
    input  logic [4:0]         commit_rd_reg_id,
    input  logic [ROB_BIT-1:0] commit_rob_entry,
    input  logic [31:0]        commit_value,
    input  logic [4:0]         rs1_id,
    input  logic [4:0]         rs2_id,
    output logic [ROB_BIT-1:0] get_rob_entry1,
    output logic [ROB_BIT-1:0] get_rob_entry2,
    input  logic               ready1,
    input  logic               ready2,
    input  logic [31:0]        value1,
    input  logic [31:0]        value2,
    output logic               rs1_busy,
    output logic               rs2_busy,
    output logic [31:0]        rs1_value,
    output logic [31:0]        rs2_value,
    output logic [ROB_BIT-1:0] rs1_rob_entry,
    output logic [ROB_BIT-1:0] rs2_rob_entry
);

    logic [31:0]        regs [0:31];
    logic [31:0]        busy;
    logic [ROB_BIT-1:0] tag  [0:31];

    // x0 is cleared on reset and never written, so it always reads zero / idle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
                tag[i]  <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 1; i < 32; i++) begin
                if (rob_commit && commit_rd_reg_id == 5'(i))
                    regs[i] <= commit_value;
                if (clear_up) begin
                    busy[i] <= 1'b0;
                end else if (issue_pollute && issue_reg_id == 5'(i)) begin
                    busy[i] <= 1'b1;
                    tag[i]  <= issue_rob_entry;
                end else if (rob_commit && commit_rd_reg_id == 5'(i) && busy[i]
                             && tag[i] == commit_rob_entry) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    logic [1:0][4:0]         src;
    logic [1:0]              q_ready;
    logic [1:0][31:0]        q_value;
    logic [1:0]              out_busy;
    logic [1:0][31:0]        out_value;
    logic [1:0][ROB_BIT-1:0] out_tag;

    assign src     = {rs2_id, rs1_id};
    assign q_ready = {ready2, ready1};
    assign q_value = {value2, value1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic        busy_k;
            logic [31:0] value_k;

            // Resolution order: committed value, same-cycle commit, ROB broadcast, pending.
            always_comb begin
                busy_k  = 1'b0;
                value_k = '0;
                if (src[gi] != 5'd0) begin
                    if (!busy[src[gi]])
                        value_k = regs[src[gi]];
                    else if (rob_commit && commit_rob_entry == tag[src[gi]])
                        value_k = commit_value;
                    else if (q_ready[gi])
                        value_k = q_value[gi];
                    else
                        busy_k = 1'b1;
                end
            end

            assign out_busy[gi]  = busy_k;
            assign out_value[gi] = value_k;
            assign out_tag[gi]   = tag[src[gi]];
        end
    endgenerate

    assign get_rob_entry1 = out_tag[0];
    assign get_rob_entry2 = out_tag[1];
    assign rs1_rob_entry  = out_tag[0];
    assign rs2_rob_entry  = out_tag[1];
    assign rs1_busy       = out_busy[0];
    assign rs2_busy       = out_busy[1];
    assign rs1_value      = out_value[0];
    assign rs2_value      = out_value[1];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected lookups from a
// behavioural register model; a monitor pops and compares every cycle.
module tb_reg_file;
    localparam int RB = 4;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, clear_up, issue_pollute, rob_commit;
    logic [4:0]    issue_reg_id, commit_rd_reg_id, rs1_id, rs2_id;
    logic [RB-1:0] issue_rob_entry, commit_rob_entry;
    logic [31:0]   commit_value, value1, value2;
    logic          ready1, ready2;
    logic [RB-1:0] get_rob_entry1, get_rob_entry2, rs1_rob_entry, rs2_rob_entry;
    logic          rs1_busy, rs2_busy;
    logic [31:0]   rs1_value, rs2_value;

    reg_file #(.ROB_BIT(RB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_up(clear_up),
        .issue_pollute(issue_pollute), .issue_reg_id(issue_reg_id),
        .issue_rob_entry(issue_rob_entry), .rob_commit(rob_commit),
        .commit_rd_reg_id(commit_rd_reg_id), .commit_rob_entry(commit_rob_entry),
        .commit_value(commit_value), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .get_rob_entry1(get_rob_entry1), .get_rob_entry2(get_rob_entry2),
        .ready1(ready1), .ready2(ready2), .value1(value1), .value2(value2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_value(rs1_value),
        .rs2_value(rs2_value), .rs1_rob_entry(rs1_rob_entry), .rs2_rob_entry(rs2_rob_entry)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic          busy;
        logic [31:0]   value;
        logic [RB-1:0] tag;
    } look_t;

    typedef struct {
        int    id;
        look_t p1;
        look_t p2;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: what each architectural register holds and who owes it.
    logic [31:0]   m_regs [32];
    logic          m_busy [32];
    logic [RB-1:0] m_tag  [32];

    int vectors = 0;
    int miscompares = 0;
    int txn = 0;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endfunction

    function automatic look_t resolve(input logic [4:0] s, input logic rdy, input logic [31:0] v);
        look_t r;
        r.tag = m_tag[s];
        r.busy = 1'b0;
        r.value = '0;
        if (s == 0) r.value = '0;
        else if (!m_busy[s]) r.value = m_regs[s];
        else if (rob_commit && commit_rob_entry == m_tag[s]) r.value = commit_value;
        else if (rdy) r.value = v;
        else r.busy = 1'b1;
        return r;
    endfunction

    task automatic idle();
        rdy_in = 1'b1; clear_up = 1'b0; issue_pollute = 1'b0; rob_commit = 1'b0;
        issue_reg_id = '0; issue_rob_entry = '0; commit_rd_reg_id = '0;
        commit_rob_entry = '0; commit_value = '0; rs1_id = '0; rs2_id = '0;
        ready1 = 1'b0; ready2 = 1'b0; value1 = '0; value2 = '0;
    endtask

    // Called just after a posedge with inputs already set: queue the expected
    // lookup, then advance the model across the next clock edge.
    task automatic step();
        exp_t e;
        e.id = txn++;
        e.p1 = resolve(rs1_id, ready1, value1);
        e.p2 = resolve(rs2_id, ready2, value2);
        exp_q.push_back(e);
        @(posedge clk_in);
        if (rdy_in) begin
            if (rob_commit && commit_rd_reg_id != 0) m_regs[commit_rd_reg_id] = commit_value;
            if (clear_up) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else begin
                if (rob_commit && commit_rd_reg_id != 0 && m_busy[commit_rd_reg_id]
                    && m_tag[commit_rd_reg_id] == commit_rob_entry)
                    m_busy[commit_rd_reg_id] = 1'b0;
                if (issue_pollute && issue_reg_id != 0) begin
                    m_busy[issue_reg_id] = 1'b1;
                    m_tag[issue_reg_id]  = issue_rob_entry;
                end
            end
        end
        #1;
        idle();
    endtask

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL txn %0d %s: got 0x%0h, expected 0x%0h", id, name, act, req);
        end
    endtask

    // Monitor: the lookup ports are combinational, so every cycle presents a result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rs1_busy", e.id, 32'(rs1_busy), 32'(e.p1.busy));
                check("rs1_value", e.id, rs1_value, e.p1.value);
                check("get_rob_entry1", e.id, 32'(get_rob_entry1), 32'(e.p1.tag));
                if (e.p1.busy) check("rs1_rob_entry", e.id, 32'(rs1_rob_entry), 32'(e.p1.tag));
                check("rs2_busy", e.id, 32'(rs2_busy), 32'(e.p2.busy));
                check("rs2_value", e.id, rs2_value, e.p2.value);
                check("get_rob_entry2", e.id, 32'(get_rob_entry2), 32'(e.p2.tag));
                if (e.p2.busy) check("rs2_rob_entry", e.id, 32'(rs2_rob_entry), 32'(e.p2.tag));
                $display("txn %0d: rs1 busy=%0d val=%h tag=%0d | rs2 busy=%0d val=%h tag=%0d",
                         e.id, rs1_busy, rs1_value, rs1_rob_entry, rs2_busy, rs2_value, rs2_rob_entry);
            end
        end
    end

    initial begin
        idle();
        model_reset();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        rs1_id = 5'd5; rs2_id = 5'd31; step();               // reset state

        issue_pollute = 1; issue_reg_id = 3; issue_rob_entry = 2; step();
        rs1_id = 3; step();                                   // pending on tag 2
        rs1_id = 3; ready1 = 1; value1 = 32'h1234; step();    // ROB broadcast
        issue_pollute = 1; issue_reg_id = 3; issue_rob_entry = 7; step();
        rob_commit = 1; commit_rd_reg_id = 3; commit_rob_entry = 2; commit_value = 32'hAA; step();
        rs1_id = 3; rs2_id = 3; step();                       // still busy, tag 7
        rob_commit = 1; commit_rd_reg_id = 3; commit_rob_entry = 7; commit_value = 32'hBB; step();
        rs1_id = 3; step();

        issue_pollute = 1; issue_reg_id = 4; issue_rob_entry = 1; step();
        rob_commit = 1; commit_rd_reg_id = 4; commit_rob_entry = 1; commit_value = 32'hC0DE;
        issue_pollute = 1; issue_reg_id = 4; issue_rob_entry = 5; rs2_id = 4; step();
        rs1_id = 4; rs2_id = 4; step();                       // issue won: busy tag 5

        issue_pollute = 1; issue_reg_id = 0; issue_rob_entry = 3;
        rob_commit = 1; commit_rd_reg_id = 0; commit_value = 32'hDEAD; rs1_id = 0; step();
        rs1_id = 0; rs2_id = 0; step();

        issue_pollute = 1; issue_reg_id = 1; issue_rob_entry = 1; step();
        issue_pollute = 1; issue_reg_id = 2; issue_rob_entry = 2; step();
        rdy_in = 0; clear_up = 1; issue_pollute = 1; issue_reg_id = 6; issue_rob_entry = 9; step();
        rs1_id = 1; rs2_id = 2; step();                       // still busy after paused flush
        clear_up = 1; issue_pollute = 1; issue_reg_id = 6; issue_rob_entry = 9; step();
        rs1_id = 1; rs2_id = 6; step();
        rs1_id = 2; step();

        issue_pollute = 1; issue_reg_id = 5; issue_rob_entry = 4; step();
        rs1_id = 5; step();
        #1 rst_in = 1'b1;                                     // pulse between edges
        #2 rst_in = 1'b0;
        model_reset();
        rs1_id = 5; rs2_id = 3; step();

        for (int n = 0; n < 400; n++) begin
            rdy_in           = ($urandom_range(0, 9) != 0);
            clear_up         = ($urandom_range(0, 19) == 0);
            issue_pollute    = $urandom_range(0, 1);
            issue_reg_id     = 5'($urandom_range(0, 7));
            issue_rob_entry  = RB'($urandom_range(0, 15));
            rob_commit       = $urandom_range(0, 1);
            commit_rd_reg_id = 5'($urandom_range(0, 7));
            commit_rob_entry = (m_busy[commit_rd_reg_id] && $urandom_range(0, 2) != 0)
                               ? m_tag[commit_rd_reg_id] : RB'($urandom_range(0, 15));
            commit_value     = $urandom;
            rs1_id           = 5'($urandom_range(0, 8));
            rs2_id           = 5'($urandom_range(0, 8));
            ready1           = ($urandom_range(0, 3) == 0);
            ready2           = ($urandom_range(0, 3) == 0);
            value1           = $urandom;
            value2           = $urandom;
            step();
        end

        repeat (2) @(posedge clk_in);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
